br_history_checkpoint_queue: RTL and testbench
==============================================

Name: br_history_checkpoint_queue

Overview:
Circular queue of global-history snapshots, one per predicted conditional branch, sitting between the fetch stage and the gshare predictor.
- Fetch pushes the pre-update history and the predicted direction of each conditional branch and receives a tag.
- On a mispredict from IntEx, the block returns the corrected history (snapshot shifted left, actual direction in LSB) to gshare's recoverBrHistory/recoveredBrHistory and discards all younger snapshots.
- Commit frees entries in order.

Parameters:
ENTRY_NUM, 16, queue depth (power of two, >=4)
GH_WIDTH, 10, global history width (BRANCH_GLOBAL_HISTORY_BIT_WIDTH)
FETCH_WIDTH, 2, allocation lanes per cycle
COMMIT_WIDTH, 2, release lanes per cycle
TAG_WIDTH, $clog2(ENTRY_NUM), entry index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
allocValid  in  FETCH_WIDTH  per-lane allocate request; lanes packed from lane 0
allocHistory  in  FETCH_WIDTH x GH_WIDTH  history before this branch updated it
allocPredTaken  in  FETCH_WIDTH  predicted direction
allocTag  out  FETCH_WIDTH x TAG_WIDTH  tag assigned per lane, combinational from tail
allocStall  out  1  free entries < popcount(allocValid); no lane allocates this cycle
mispredValid  in  1  branch resolved mispredicted
mispredTag  in  TAG_WIDTH  tag of that branch
mispredTaken  in  1  actual direction
releaseNum  in  $clog2(COMMIT_WIDTH+1)  entries to free from head, in order
recoverBrHistory  out  1  registered, one-cycle pulse
recoveredBrHistory  out  GH_WIDTH  corrected history, valid with pulse
count  out  TAG_WIDTH+1  occupied entries
empty  out  1  count==0
full  out  1  count==ENTRY_NUM

Behaviour:
- Pointers: head and tail are TAG_WIDTH+1 bits with a wrap bit.
  - full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - count = tail-head, modulo 2^(TAG_WIDTH+1).
- Reset values: head=tail=0, recoverBrHistory=0, recoveredBrHistory=0, empty=1, full=0, count=0. Entry contents are not reset. Reset asserted mid-operation discards all entries on the next edge.
- Allocation:
  - Lane i tag = tail + (number of valid lanes below i), truncated to TAG_WIDTH.
  - The entry stores {history, predTaken} on the clock edge.
  - tail advances by popcount(allocValid).
  - All-or-nothing: if allocStall=1, nothing is written and tail holds. allocStall is combinational and independent of the same-cycle release.
- Release: head advances by releaseNum. releaseNum > count is illegal (assertion); the design saturates head at tail.
- Mispredict (cycle N):
  - Cycle N+1: recoverBrHistory=1 and recoveredBrHistory = ({snapshot[mispredTag].history, mispredTaken} truncated to GH_WIDTH LSBs).
  - tail <= mispredTag+1, with the wrap bit reconstructed relative to head, so the mispredicted entry is kept and all younger entries are dropped.
  - A same-cycle allocation is ignored; mispred wins over alloc.
  - A same-cycle release still applies to head.
- A mispredTag outside [head, tail) is illegal (assertion). A mispredict on the entry being released in the same cycle is legal: recovery still occurs and the queue becomes empty.
- Back-to-back mispredicts are handled every cycle. The later pulse carries its own tag's history; the tag must still be live after the prior truncation.
- Wrap-around: tags wrap modulo ENTRY_NUM; allocation across the boundary in a single cycle is legal.
- recoverBrHistory is asserted only in the cycle after a mispredValid and is otherwise 0.

Decomposition:
- FetchUnitTypes holds:
  - BrHistoryCheckpointEntry struct {history, predTaken}
  - BrCheckpointTagPath typedef
  - BR_CHECKPOINT_ENTRY_NUM constant
- Reuse BranchGlobalHistoryPath for the history field.
- Sub-module: a multi-push pointer unit, br_checkpoint_pointer. It owns head/tail/wrap logic, count/full/empty, variable push/pop, and tail truncation.
- Entry storage is a flop array inside the top.

Test Plan:
1. Reset, then allocate lanes 0,1 with histories 0x005/0x00A, pred 1/0 → tags 0,1; count=2; empty=0.
2. Mispredict tag 0, taken=0, with history 0x005 → next cycle recoverBrHistory=1, recoveredBrHistory=0x00A; count=1; the following allocation gets tag 1.
3. Fill to 16 entries, then request 1 allocation → allocStall=1, full=1, tail unchanged. Release 2 → the next allocation of 2 succeeds.
4. With head=14, allocate 4 across the wrap → tags 14,15,0,1. Mispredict tag 15 → count=2; recovered history = (hist15<<1)|taken truncated to 10 bits.
5. Same cycle: allocValid=2'b11, mispred tag 3, releaseNum=1 → no allocation, head+1, tail=4, pulse next cycle only.
6. Assert rst while count=7 and mispredValid=1 → next cycle count=0, empty=1, recoverBrHistory=0.

Source files
------------

// File: rtl/br_history_checkpoint_queue_pkg.sv
// Shared fetch-unit types for the branch-history checkpoint queue.
// Holds the global-history width, the checkpoint depth, the tag type and the
// per-entry snapshot layout, plus the helper that builds a corrected history.
package br_history_checkpoint_queue_pkg;

  localparam int BR_CHECKPOINT_ENTRY_NUM         = 16;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 10;
  localparam int BR_CHECKPOINT_TAG_WIDTH         = $clog2(BR_CHECKPOINT_ENTRY_NUM);
  localparam int BR_CHECKPOINT_FETCH_WIDTH       = 2;
  localparam int BR_CHECKPOINT_COMMIT_WIDTH      = 2;

  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [BR_CHECKPOINT_TAG_WIDTH-1:0]         BrCheckpointTagPath;

  typedef struct packed {
    BranchGlobalHistoryPath history;
    logic                   predTaken;
  } BrHistoryCheckpointEntry;

  // History as it should have been after the branch: the pre-branch snapshot
  // shifted left with the resolved direction in the LSB; the oldest bit falls off.
  function automatic BranchGlobalHistoryPath CorrectedHistory(
    input BranchGlobalHistoryPath history,
    input logic                   taken
  );
    return BranchGlobalHistoryPath'({history, taken});
  endfunction

endpackage

// File: rtl/br_history_checkpoint_queue_if.sv
// Fetch / IntEx / commit side connection of the checkpoint queue.
//   master : fetch, IntEx and commit drive requests, receive tags and recovery
//   slave  : the queue itself
// Signals: allocValid/allocHistory/allocPredTaken -> allocTag/allocStall,
//          mispredValid/mispredTag/mispredTaken -> recoverBrHistory/recoveredBrHistory,
//          releaseNum (entries retired from the head).
interface br_history_checkpoint_queue_if #(
  parameter int ENTRY_NUM    = 16,
  parameter int GH_WIDTH     = 10,
  parameter int FETCH_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
);
  localparam int TAG_WIDTH     = $clog2(ENTRY_NUM);
  localparam int RELEASE_WIDTH = $clog2(COMMIT_WIDTH + 1);

  logic [FETCH_WIDTH-1:0]                allocValid;
  logic [FETCH_WIDTH-1:0][GH_WIDTH-1:0]  allocHistory;
  logic [FETCH_WIDTH-1:0]                allocPredTaken;
  logic [FETCH_WIDTH-1:0][TAG_WIDTH-1:0] allocTag;
  logic                                  allocStall;

  logic                                  mispredValid;
  logic [TAG_WIDTH-1:0]                  mispredTag;
  logic                                  mispredTaken;

  logic [RELEASE_WIDTH-1:0]              releaseNum;

  logic                                  recoverBrHistory;
  logic [GH_WIDTH-1:0]                   recoveredBrHistory;

  modport master (
    output allocValid, allocHistory, allocPredTaken,
    output mispredValid, mispredTag, mispredTaken,
    output releaseNum,
    input  allocTag, allocStall, recoverBrHistory, recoveredBrHistory
  );

  modport slave (
    input  allocValid, allocHistory, allocPredTaken,
    input  mispredValid, mispredTag, mispredTaken,
    input  releaseNum,
    output allocTag, allocStall, recoverBrHistory, recoveredBrHistory
  );

endinterface

// File: rtl/br_checkpoint_pointer.sv
// Head/tail pointer pair for a multi-push, multi-pop circular queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports: pushNum (entries appended at tail), popNum (entries retired at head),
//        truncate/truncTag (cut the tail back to just after truncTag),
//        tail, count, full, empty.
module br_checkpoint_pointer #(
  parameter int ENTRY_NUM      = 16,
  parameter int PUSH_NUM_WIDTH = 2,
  parameter int POP_NUM_WIDTH  = 2,
  localparam int TAG_WIDTH     = $clog2(ENTRY_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PUSH_NUM_WIDTH-1:0] pushNum,
  input  logic [POP_NUM_WIDTH-1:0]  popNum,
  input  logic                      truncate,
  input  logic [TAG_WIDTH-1:0]      truncTag,
  output logic [TAG_WIDTH:0]        tail,
  output logic [TAG_WIDTH:0]        count,
  output logic                      full,
  output logic                      empty
);

  typedef logic [TAG_WIDTH:0] PtrPath;

  PtrPath head;
  PtrPath headNext;
  PtrPath tailNext;
  PtrPath truncOffset;
  PtrPath liveAfter;
  PtrPath popEff;

  // The truncation tag has no wrap bit; its distance from head rebuilds it.
  always_comb begin
    truncOffset = {1'b0, truncTag - head[TAG_WIDTH-1:0]};
    tailNext    = truncate ? head + truncOffset + PtrPath'(1)
                           : tail + PtrPath'(pushNum);
    // Head may never overtake the (possibly truncated) tail.
    liveAfter   = tailNext - head;
    popEff      = (PtrPath'(popNum) > liveAfter) ? liveAfter : PtrPath'(popNum);
    headNext    = head + popEff;
  end

  assign count = tail - head;
  assign empty = (head == tail);
  assign full  = (head[TAG_WIDTH] != tail[TAG_WIDTH]) &&
                 (head[TAG_WIDTH-1:0] == tail[TAG_WIDTH-1:0]);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= headNext;
      tail <= tailNext;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (PtrPath'(popNum) <= count);
      if (truncate) assert (truncOffset < count);
    end
  end

endmodule

// File: rtl/br_history_checkpoint_queue.sv
// Circular queue of global-history snapshots, one per predicted conditional
// branch. Fetch allocates entries and gets tags back; a mispredict returns
// the corrected history to gshare one cycle later and drops younger entries;
// commit releases entries from the head in order.
// Ports: clk, rst (sync, active high), bus (slave side of the queue
//        interface), count / empty / full occupancy status.
// GH_WIDTH must match the package history width used for entry storage.
module br_history_checkpoint_queue
  import br_history_checkpoint_queue_pkg::*;
#(
  parameter int ENTRY_NUM    = BR_CHECKPOINT_ENTRY_NUM,
  parameter int GH_WIDTH     = BRANCH_GLOBAL_HISTORY_BIT_WIDTH,
  parameter int FETCH_WIDTH  = BR_CHECKPOINT_FETCH_WIDTH,
  parameter int COMMIT_WIDTH = BR_CHECKPOINT_COMMIT_WIDTH,
  localparam int TAG_WIDTH   = $clog2(ENTRY_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  br_history_checkpoint_queue_if.slave bus,
  output logic [TAG_WIDTH:0]     count,
  output logic                   empty,
  output logic                   full
);

  localparam int PUSH_NUM_WIDTH = $clog2(FETCH_WIDTH + 1);
  localparam int POP_NUM_WIDTH  = $clog2(COMMIT_WIDTH + 1);

  typedef logic [TAG_WIDTH:0]      PtrPath;
  typedef logic [PUSH_NUM_WIDTH-1:0] PushNumPath;

  BrHistoryCheckpointEntry entries [ENTRY_NUM];

  PtrPath     tail;
  PushNumPath validCount;
  PushNumPath pushNum;
  logic       doAlloc;

  // Tag of each lane is tail plus the number of valid lanes below it.
  always_comb begin
    validCount = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bus.allocTag[i] = tail[TAG_WIDTH-1:0] + TAG_WIDTH'(validCount);
      if (bus.allocValid[i]) validCount += PushNumPath'(1);
    end
  end

  // Stall depends only on current occupancy, never on this cycle's release.
  assign bus.allocStall = PtrPath'(validCount) > (PtrPath'(ENTRY_NUM) - count);
  assign doAlloc        = !bus.allocStall && !bus.mispredValid;
  assign pushNum        = doAlloc ? validCount : '0;

  br_checkpoint_pointer #(
    .ENTRY_NUM      (ENTRY_NUM),
    .PUSH_NUM_WIDTH (PUSH_NUM_WIDTH),
    .POP_NUM_WIDTH  (POP_NUM_WIDTH)
  ) pointer (
    .clk      (clk),
    .rst      (rst),
    .pushNum  (pushNum),
    .popNum   (bus.releaseNum),
    .truncate (bus.mispredValid),
    .truncTag (bus.mispredTag),
    .tail     (tail),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // NOTE: snapshot storage has no reset; validity is tracked purely by the
  // pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (doAlloc && bus.allocValid[i]) begin
        entries[bus.allocTag[i]] <= '{history: bus.allocHistory[i],
                                      predTaken: bus.allocPredTaken[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.recoverBrHistory   <= 1'b0;
      bus.recoveredBrHistory <= '0;
    end else begin
      bus.recoverBrHistory <= bus.mispredValid;
      if (bus.mispredValid) begin
        bus.recoveredBrHistory <= CorrectedHistory(entries[bus.mispredTag].history,
                                                   bus.mispredTaken);
      end
    end
  end

  // A mispredict must contradict the direction that was predicted.
  always @(posedge clk) begin
    if (!rst && bus.mispredValid) begin
      assert (entries[bus.mispredTag].predTaken != bus.mispredTaken);
    end
  end

endmodule

// File: tb/tb_br_history_checkpoint_queue.sv
// Directed bench for br_history_checkpoint_queue: allocation, stall when
// full, wrap-around, mispredict recovery, combined mispredict/alloc/release,
// reset mid-operation and back-to-back mispredicts.
module tb_br_history_checkpoint_queue;

  localparam int ENTRY_NUM    = 16;
  localparam int GH_WIDTH     = 10;
  localparam int FETCH_WIDTH  = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int TAG_WIDTH    = $clog2(ENTRY_NUM);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [TAG_WIDTH:0]   count;
  logic                 empty;
  logic                 full;

  int checks = 0;
  int errors = 0;

  br_history_checkpoint_queue_if #(
    .ENTRY_NUM(ENTRY_NUM), .GH_WIDTH(GH_WIDTH),
    .FETCH_WIDTH(FETCH_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH)
  ) bus ();

  br_history_checkpoint_queue #(
    .ENTRY_NUM(ENTRY_NUM), .GH_WIDTH(GH_WIDTH),
    .FETCH_WIDTH(FETCH_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.allocValid     = '0;
    bus.allocHistory   = '0;
    bus.allocPredTaken = '0;
    bus.mispredValid   = 1'b0;
    bus.mispredTag     = '0;
    bus.mispredTaken   = 1'b0;
    bus.releaseNum     = '0;
  endtask

  task automatic setAlloc(input logic [1:0] valid,
                          input logic [GH_WIDTH-1:0] h0, input logic p0,
                          input logic [GH_WIDTH-1:0] h1, input logic p1);
    bus.allocValid        = valid;
    bus.allocHistory[0]   = h0;
    bus.allocPredTaken[0] = p0;
    bus.allocHistory[1]   = h1;
    bus.allocPredTaken[1] = p1;
  endtask

  task automatic setMispred(input logic [TAG_WIDTH-1:0] tag, input logic taken);
    bus.mispredValid = 1'b1;
    bus.mispredTag   = tag;
    bus.mispredTaken = taken;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_recover", 32'(bus.recoverBrHistory), 0);
    check("rst_recovered", 32'(bus.recoveredBrHistory), 0);

    // 1. Two-lane allocation: tags 0,1
    setAlloc(2'b11, 10'h005, 1'b1, 10'h00A, 1'b0);
    #1;
    check("s1_tag0", 32'(bus.allocTag[0]), 0);
    check("s1_tag1", 32'(bus.allocTag[1]), 1);
    check("s1_stall", 32'(bus.allocStall), 0);
    tick();
    idle();
    check("s1_count", 32'(count), 2);
    check("s1_empty", 32'(empty), 0);

    // 2. Mispredict tag 0, actual not-taken: {0x005,0} = 0x00A
    setMispred(4'd0, 1'b0);
    tick();
    idle();
    check("s2_recover", 32'(bus.recoverBrHistory), 1);
    check("s2_recovered", 32'(bus.recoveredBrHistory), 32'h00A);
    check("s2_count", 32'(count), 1);
    check("s2_next_tag", 32'(bus.allocTag[0]), 1);
    setAlloc(2'b01, 10'h3FF, 1'b1, 10'h000, 1'b0);
    tick();
    idle();
    check("s2_pulse_end", 32'(bus.recoverBrHistory), 0);
    check("s2_count2", 32'(count), 2);

    // 3. Fill tags 2..15: history = 0x100 + 3*tag, predicted not-taken
    for (int k = 0; k < 7; k++) begin
      setAlloc(2'b11, GH_WIDTH'(32'h100 + 3 * (2 + 2 * k)), 1'b0,
                      GH_WIDTH'(32'h100 + 3 * (3 + 2 * k)), 1'b0);
      tick();
    end
    idle();
    check("s3_count_full", 32'(count), 16);
    check("s3_full", 32'(full), 1);
    setAlloc(2'b01, 10'h111, 1'b0, 10'h000, 1'b0);
    #1;
    check("s3_stall", 32'(bus.allocStall), 1);
    tick();
    idle();
    check("s3_count_held", 32'(count), 16);
    check("s3_tail_held", 32'(bus.allocTag[0]), 0);
    bus.releaseNum = 2'd2;
    tick();
    idle();
    check("s3_count_rel", 32'(count), 14);
    check("s3_full_rel", 32'(full), 0);
    setAlloc(2'b11, 10'h0AA, 1'b0, 10'h0BB, 1'b0);
    #1;
    check("s3_stall_rel", 32'(bus.allocStall), 0);
    check("s3_tag0_rel", 32'(bus.allocTag[0]), 0);
    check("s3_tag1_rel", 32'(bus.allocTag[1]), 1);
    tick();
    idle();
    check("s3_count_refill", 32'(count), 16);

    // Mispredict tag 13 (hist 0x127) taken: 0x24F; keeps tags 2..13
    setMispred(4'd13, 1'b1);
    tick();
    idle();
    check("s4a_recovered", 32'(bus.recoveredBrHistory), 32'h24F);
    check("s4a_count", 32'(count), 12);
    for (int k = 0; k < 6; k++) begin
      bus.releaseNum = 2'd2;
      tick();
    end
    idle();
    check("s4a_empty", 32'(empty), 1);
    check("s4a_tail", 32'(bus.allocTag[0]), 14);

    // 4. Allocate across the wrap: 14, then 15 and 0 in one cycle, then 1
    setAlloc(2'b01, 10'h0E0, 1'b0, 10'h000, 1'b0);
    tick();
    setAlloc(2'b11, 10'h2AB, 1'b0, 10'h0F0, 1'b0);
    #1;
    check("s4_tag15", 32'(bus.allocTag[0]), 15);
    check("s4_tag0", 32'(bus.allocTag[1]), 0);
    tick();
    setAlloc(2'b01, 10'h0F1, 1'b0, 10'h000, 1'b0);
    #1;
    check("s4_tag1", 32'(bus.allocTag[0]), 1);
    tick();
    idle();
    check("s4_count", 32'(count), 4);
    // {0x2AB,1} truncated to 10 bits = 0x157
    setMispred(4'd15, 1'b1);
    tick();
    idle();
    check("s4_recover", 32'(bus.recoverBrHistory), 1);
    check("s4_recovered", 32'(bus.recoveredBrHistory), 32'h157);
    check("s4_count_trunc", 32'(count), 2);
    check("s4_tail_trunc", 32'(bus.allocTag[0]), 0);

    // 5. Tags 0..3, then mispred tag 3 + alloc + release in one cycle
    setAlloc(2'b11, 10'h011, 1'b0, 10'h022, 1'b0);
    tick();
    setAlloc(2'b11, 10'h033, 1'b0, 10'h344, 1'b1);
    tick();
    idle();
    check("s5_count_pre", 32'(count), 6);
    setAlloc(2'b11, 10'h155, 1'b0, 10'h166, 1'b0);
    setMispred(4'd3, 1'b0);
    bus.releaseNum = 2'd1;
    tick();
    idle();
    check("s5_recover", 32'(bus.recoverBrHistory), 1);
    check("s5_recovered", 32'(bus.recoveredBrHistory), 32'h288);
    check("s5_count", 32'(count), 5);
    check("s5_tail", 32'(bus.allocTag[0]), 4);
    tick();
    check("s5_pulse_end", 32'(bus.recoverBrHistory), 0);

    // 6. Reset with 7 live entries and a mispredict pending
    setAlloc(2'b11, 10'h177, 1'b0, 10'h188, 1'b0);
    tick();
    idle();
    check("s6_count_pre", 32'(count), 7);
    setMispred(4'd5, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("s6_count", 32'(count), 0);
    check("s6_empty", 32'(empty), 1);
    check("s6_recover", 32'(bus.recoverBrHistory), 0);
    check("s6_tail", 32'(bus.allocTag[0]), 0);

    // Back-to-back mispredicts, then mispredict on the entry being released
    setAlloc(2'b11, 10'h001, 1'b1, 10'h002, 1'b0);
    tick();
    setAlloc(2'b11, 10'h003, 1'b0, 10'h004, 1'b1);
    tick();
    idle();
    setMispred(4'd2, 1'b1);
    tick();
    check("b2b_recover1", 32'(bus.recoverBrHistory), 1);
    check("b2b_recovered1", 32'(bus.recoveredBrHistory), 32'h007);
    check("b2b_count1", 32'(count), 3);
    setMispred(4'd0, 1'b0);
    tick();
    check("b2b_recover2", 32'(bus.recoverBrHistory), 1);
    check("b2b_recovered2", 32'(bus.recoveredBrHistory), 32'h002);
    check("b2b_count2", 32'(count), 1);
    setMispred(4'd0, 1'b0);
    bus.releaseNum = 2'd1;
    tick();
    idle();
    check("relmis_recover", 32'(bus.recoverBrHistory), 1);
    check("relmis_count", 32'(count), 0);
    check("relmis_empty", 32'(empty), 1);
    tick();
    check("relmis_pulse_end", 32'(bus.recoverBrHistory), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
